// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spu_pkg
//  Description : Shared definitions for the odd-pipe register-fetch/forward
//                stage: unit encodings, result latencies, scoreboard entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package spu_pkg;

    // Execution unit encodings carried on in_unit / unit.
    localparam logic [1:0] UNIT_PERM = 2'd0;
    localparam logic [1:0] UNIT_LS   = 2'd1;
    localparam logic [1:0] UNIT_BR   = 2'd2;

    // Age at which each unit's result first appears on the forwarding bus.
    localparam int C_LAT_PERM = 4;
    localparam int C_LAT_LS   = 6;
    localparam int C_LAT_BR   = 1;

    // One in-flight odd-pipe write.
    typedef struct packed {
        logic       valid;
        logic [0:6] addr;
        logic [2:0] lat;
    } sb_entry_t;

endpackage : spu_pkg
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Combinational per-operand source select. The youngest
//                forwarding slot (lowest index 1..6) wins, then the
//                writeback bus, then register-file data. Slot 0 is not an
//                input at all, so it can never be selected.
//  Ports       : i_src_addr   - register being read
//                i_rf_data    - register-file read data for i_src_addr
//                i_fw_wb      - forwarding values, slots 6..1
//                i_fw_addr_wb - forwarding addresses, slots 6..1
//                i_fw_write   - forwarding valid bits, slots 6..1
//                i_rt_wb / i_rt_addr_wb / i_reg_write_wb - writeback bus
//                o_data       - resolved operand
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select (
    input  logic [0:6]         i_src_addr,
    input  logic [0:127]       i_rf_data,
    input  logic [6:1][0:127]  i_fw_wb,
    input  logic [6:1][0:6]    i_fw_addr_wb,
    input  logic [6:1]         i_fw_write,
    input  logic [0:127]       i_rt_wb,
    input  logic [0:6]         i_rt_addr_wb,
    input  logic               i_reg_write_wb,
    output logic [0:127]       o_data
);

    logic [0:127] w_data;

    // Lowest-priority source assigned first; the slot loop runs from the
    // oldest slot down so the youngest matching slot is the last writer.
    always_comb begin
        w_data = i_rf_data;
        if (i_reg_write_wb && (i_rt_addr_wb == i_src_addr)) begin
            w_data = i_rt_wb;
        end
        for (int k = 6; k >= 1; k--) begin
            if (i_fw_write[k] && (i_fw_addr_wb[k] == i_src_addr)) begin
                w_data = i_fw_wb[k];
            end
        end
    end

    assign o_data = w_data;

endmodule : fwd_select
`default_nettype wire

// File: rtl/odd_operand_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : odd_operand_fwd
//  Description : Register-fetch/forward stage feeding the odd pipe. Tracks
//                in-flight odd-pipe writes in an aging scoreboard, stalls
//                decode until a needed result reaches a forwarding slot, and
//                resolves ra/rb/rt_st from forwarding, writeback or the
//                register file into a one-cycle output register.
//  Ports       : clk, reset                  - clock, sync active-high reset
//                in_valid/in_ready/in_*      - decoded instruction handshake
//                rf_*_addr / rf_*            - register-file read port
//                fw_wb/fw_addr_wb/fw_write_wb - odd-pipe forwarding bus
//                rt_wb/rt_addr_wb/reg_write_wb - odd-pipe writeback
//                flush                       - branch taken, squash issue
//                op..pc_out, ra/rb/rt_st     - registered issue to odd pipe
//                out_valid                   - output register holds an instr
//                stall_cnt                   - saturating hazard-stall count
//  Revision    : 1.0 - initial release
// ============================================================================
module odd_operand_fwd
    import spu_pkg::*;
#(
    parameter int DEPTH    = 7,
    parameter int LAT_PERM = C_LAT_PERM,
    parameter int LAT_LS   = C_LAT_LS,
    parameter int LAT_BR   = C_LAT_BR,
    parameter int STALL_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    // Decode side
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:10]         in_op,
    input  logic [2:0]          in_format,
    input  logic [1:0]          in_unit,
    input  logic [0:6]          in_rt_addr,
    input  logic [0:6]          in_ra_addr,
    input  logic [0:6]          in_rb_addr,
    input  logic [0:6]          in_rc_addr,
    input  logic                in_use_ra,
    input  logic                in_use_rb,
    input  logic                in_use_rc,
    input  logic [0:17]         in_imm,
    input  logic                in_reg_write,
    input  logic [7:0]          in_pc,
    // Register file
    output logic [0:6]          rf_ra_addr,
    output logic [0:6]          rf_rb_addr,
    output logic [0:6]          rf_rc_addr,
    input  logic [0:127]        rf_ra,
    input  logic [0:127]        rf_rb,
    input  logic [0:127]        rf_rc,
    // Odd-pipe forwarding and writeback
    input  logic [6:0][0:127]   fw_wb,
    input  logic [6:0][0:6]     fw_addr_wb,
    input  logic [6:0]          fw_write_wb,
    input  logic [0:127]        rt_wb,
    input  logic [0:6]          rt_addr_wb,
    input  logic                reg_write_wb,
    input  logic                flush,
    // Issue to the odd pipe
    output logic [0:10]         op,
    output logic [2:0]          format,
    output logic [1:0]          unit,
    output logic [0:6]          rt_addr,
    output logic [0:17]         imm,
    output logic                reg_write,
    output logic [7:0]          pc_out,
    output logic [0:127]        ra,
    output logic [0:127]        rb,
    output logic [0:127]        rt_st,
    output logic                out_valid,
    output logic [STALL_W-1:0]  stall_cnt
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    sb_entry_t          r_sb [1:DEPTH];

    logic [0:10]        r_op;
    logic [2:0]         r_format;
    logic [1:0]         r_unit;
    logic [0:6]         r_rt_addr;
    logic [0:17]        r_imm;
    logic               r_reg_write;
    logic [7:0]         r_pc;
    logic [0:127]       r_ra;
    logic [0:127]       r_rb;
    logic [0:127]       r_rt_st;
    logic               r_out_valid;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_hazard;
    logic               w_dispatch;
    logic [2:0]         w_lat;
    logic [0:127]       w_ra;
    logic [0:127]       w_rb;
    logic [0:127]       w_rc;
    logic               w_unused_fw0;

    // Slot 0 holds a result that is already one cycle from writeback and is
    // deliberately never forwarded from.
    assign w_unused_fw0 = ^{fw_wb[0], fw_addr_wb[0], fw_write_wb[0]};

    // ------------------------------------------------------------------
    // Register-file addresses are straight copies of the decode sources.
    // ------------------------------------------------------------------
    assign rf_ra_addr = in_ra_addr;
    assign rf_rb_addr = in_rb_addr;
    assign rf_rc_addr = in_rc_addr;

    // ------------------------------------------------------------------
    // Result latency of the instruction in decode. Unit 3 behaves as perm.
    // ------------------------------------------------------------------
    always_comb begin
        w_lat = 3'(LAT_PERM);
        case (in_unit)
            UNIT_LS: w_lat = 3'(LAT_LS);
            UNIT_BR: w_lat = 3'(LAT_BR);
            default: w_lat = 3'(LAT_PERM);
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard: a used source hits an in-flight write that has not yet aged
    // into the forwarding slot where its result becomes visible. Each entry
    // is checked on its own, so duplicate addresses need no special case.
    // ------------------------------------------------------------------
    always_comb begin
        w_hazard = 1'b0;
        for (int a = 1; a <= DEPTH; a++) begin
            if (r_sb[a].valid && (a < int'(r_sb[a].lat))) begin
                if (in_use_ra && (r_sb[a].addr == in_ra_addr)) w_hazard = 1'b1;
                if (in_use_rb && (r_sb[a].addr == in_rb_addr)) w_hazard = 1'b1;
                if (in_use_rc && (r_sb[a].addr == in_rc_addr)) w_hazard = 1'b1;
            end
        end
    end

    // in_ready is reported even during flush; flush only blocks dispatch.
    assign in_ready   = !w_hazard;
    assign w_dispatch = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------
    // Operand resolution
    // ------------------------------------------------------------------
    fwd_select u_sel_ra (
        .i_src_addr     (in_ra_addr),
        .i_rf_data      (rf_ra),
        .i_fw_wb        (fw_wb[6:1]),
        .i_fw_addr_wb   (fw_addr_wb[6:1]),
        .i_fw_write     (fw_write_wb[6:1]),
        .i_rt_wb        (rt_wb),
        .i_rt_addr_wb   (rt_addr_wb),
        .i_reg_write_wb (reg_write_wb),
        .o_data         (w_ra)
    );

    fwd_select u_sel_rb (
        .i_src_addr     (in_rb_addr),
        .i_rf_data      (rf_rb),
        .i_fw_wb        (fw_wb[6:1]),
        .i_fw_addr_wb   (fw_addr_wb[6:1]),
        .i_fw_write     (fw_write_wb[6:1]),
        .i_rt_wb        (rt_wb),
        .i_rt_addr_wb   (rt_addr_wb),
        .i_reg_write_wb (reg_write_wb),
        .o_data         (w_rb)
    );

    fwd_select u_sel_rc (
        .i_src_addr     (in_rc_addr),
        .i_rf_data      (rf_rc),
        .i_fw_wb        (fw_wb[6:1]),
        .i_fw_addr_wb   (fw_addr_wb[6:1]),
        .i_fw_write     (fw_write_wb[6:1]),
        .i_rt_wb        (rt_wb),
        .i_rt_addr_wb   (rt_addr_wb),
        .i_reg_write_wb (reg_write_wb),
        .o_data         (w_rc)
    );

    // ------------------------------------------------------------------
    // Scoreboard: shifts every cycle; age 1 takes the dispatched write or
    // an invalid slot. Entries fall off after age DEPTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 1; a <= DEPTH; a++) begin
                r_sb[a] <= '0;
            end
        end else begin
            for (int a = 2; a <= DEPTH; a++) begin
                r_sb[a] <= r_sb[a-1];
            end
            if (w_dispatch) begin
                r_sb[1].valid <= in_reg_write;
                r_sb[1].addr  <= in_rt_addr;
                r_sb[1].lat   <= w_lat;
            end else begin
                r_sb[1] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register: a dispatched instruction or an all-zero bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || !w_dispatch) begin
            r_op        <= '0;
            r_format    <= '0;
            r_unit      <= '0;
            r_rt_addr   <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_pc        <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_rt_st     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_op        <= in_op;
            r_format    <= in_format;
            r_unit      <= in_unit;
            r_rt_addr   <= in_rt_addr;
            r_imm       <= in_imm;
            r_reg_write <= in_reg_write;
            r_pc        <= in_pc;
            r_ra        <= w_ra;
            r_rb        <= w_rb;
            r_rt_st     <= w_rc;
            r_out_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hazard-stall counter. A flushed cycle is not counted as a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign op        = r_op;
    assign format    = r_format;
    assign unit      = r_unit;
    assign rt_addr   = r_rt_addr;
    assign imm       = r_imm;
    assign reg_write = r_reg_write;
    assign pc_out    = r_pc;
    assign ra        = r_ra;
    assign rb        = r_rb;
    assign rt_st     = r_rt_st;
    assign out_valid = r_out_valid;
    assign stall_cnt = r_stall_cnt;

endmodule : odd_operand_fwd
`default_nettype wire

// File: tb/tb_odd_operand_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odd_operand_fwd
//  Description : Directed self-checking bench for odd_operand_fwd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_operand_fwd;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [0:10]        in_op;
    logic [2:0]         in_format;
    logic [1:0]         in_unit;
    logic [0:6]         in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
    logic               in_use_ra, in_use_rb, in_use_rc;
    logic [0:17]        in_imm;
    logic               in_reg_write;
    logic [7:0]         in_pc;
    logic [0:6]         rf_ra_addr, rf_rb_addr, rf_rc_addr;
    logic [0:127]       rf_ra, rf_rb, rf_rc;
    logic [6:0][0:127]  fw_wb;
    logic [6:0][0:6]    fw_addr_wb;
    logic [6:0]         fw_write_wb;
    logic [0:127]       rt_wb;
    logic [0:6]         rt_addr_wb;
    logic               reg_write_wb;
    logic               flush;
    logic [0:10]        op;
    logic [2:0]         format;
    logic [1:0]         unit;
    logic [0:6]         rt_addr;
    logic [0:17]        imm;
    logic               reg_write;
    logic [7:0]         pc_out;
    logic [0:127]       ra, rb, rt_st;
    logic               out_valid;
    logic [15:0]        stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Register-file model: a recognisable value derived from the address.
    function automatic logic [0:127] rf_value(input logic [0:6] a);
        return {64'hDEAD_BEEF_0000_0000, 57'h0, a};
    endfunction

    assign rf_ra = rf_value(rf_ra_addr);
    assign rf_rb = rf_value(rf_rb_addr);
    assign rf_rc = rf_value(rf_rc_addr);

    odd_operand_fwd dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_format(in_format), .in_unit(in_unit), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
        .in_imm(in_imm), .in_reg_write(in_reg_write), .in_pc(in_pc),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_rc_addr(rf_rc_addr),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rc(rf_rc),
        .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb), .fw_write_wb(fw_write_wb),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .flush(flush),
        .op(op), .format(format), .unit(unit), .rt_addr(rt_addr), .imm(imm),
        .reg_write(reg_write), .pc_out(pc_out), .ra(ra), .rb(rb), .rt_st(rt_st),
        .out_valid(out_valid), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        fw_wb        = '0;
        fw_addr_wb   = '0;
        fw_write_wb  = '0;
        rt_wb        = '0;
        rt_addr_wb   = '0;
        reg_write_wb = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] u, input logic [0:6] rt,
                             input logic [0:6] a, input logic [0:6] b,
                             input logic [0:6] c, input logic ua,
                             input logic ub, input logic uc,
                             input logic rw, input logic [7:0] pc);
        in_valid     = 1'b1;
        in_unit      = u;
        in_rt_addr   = rt;
        in_ra_addr   = a;
        in_rb_addr   = b;
        in_rc_addr   = c;
        in_use_ra    = ua;
        in_use_rb    = ub;
        in_use_rc    = uc;
        in_reg_write = rw;
        in_pc        = pc;
        in_op        = {3'b101, pc};
        in_format    = pc[2:0];
        in_imm       = {10'h0, pc};
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        in_valid = 1'b0; flush = 1'b0; clear_bus();
        set_instr(2'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        in_valid = 1'b0;
        reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
        n_vec++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0 || op !== 11'd0 || pc_out !== 8'd0) begin
            n_err++; $display("FAIL reset_outputs: out_valid=%b reg_write=%b op=%h pc=%h, expected all 0", out_valid, reg_write, op, pc_out);
        end
        n_vec++;
        if (ra !== 128'd0 || rb !== 128'd0 || rt_st !== 128'd0) begin
            n_err++; $display("FAIL reset_operands: ra=%h rb=%h rt_st=%h, expected 0", ra, rb, rt_st);
        end
        n_vec++;
        if (stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ctrl: stall_cnt=%0d in_ready=%b, expected 0 and 1", stall_cnt, in_ready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_independent();
        logic [0:6] rts [3];
        logic [0:6] ras [3];
        logic [0:6] rbs [3];
        do_reset();
        rts = '{7'd1, 7'd4, 7'd6};
        ras = '{7'd2, 7'd10, 7'd12};
        rbs = '{7'd3, 7'd11, 7'd13};
        for (int i = 0; i < 3; i++) begin
            set_instr(2'd0, rts[i], ras[i], rbs[i], 7'd30, 1'b1, 1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL indep_ready[%0d]: in_ready=%b, expected 1", i, in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || pc_out !== 8'(8'h10 + i) || op !== {3'b101, 8'(8'h10 + i)}
                || ra !== rf_value(ras[i]) || rb !== rf_value(rbs[i]) || rt_addr !== rts[i]) begin
                n_err++; $display("FAIL indep_out[%0d]: valid=%b pc=%h ra=%h rb=%h rt=%0d, expected valid=1 pc=%h ra=%h rb=%h rt=%0d",
                    i, out_valid, pc_out, ra, rb, rt_addr, 8'(8'h10 + i), rf_value(ras[i]), rf_value(rbs[i]), rts[i]);
            end
        end
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL indep_stall: stall_cnt=%0d, expected 0", stall_cnt);
        end
        idle(1);
        n_vec++;
        if (out_valid !== 1'b0 || op !== 11'd0 || reg_write !== 1'b0) begin
            n_err++; $display("FAIL indep_bubble: valid=%b op=%h reg_write=%b, expected 0 0 0", out_valid, op, reg_write);
        end
        idle(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_perm_raw();
        do_reset();
        set_instr(2'd0, 7'd5, 7'd20, 7'd21, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30);
        tick();
        set_instr(2'd0, 7'd40, 7'd5, 7'd22, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL perm_stall_ready[%0d]: in_ready=%b, expected 0", i, in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || op !== 11'd0) begin
                n_err++; $display("FAIL perm_bubble[%0d]: valid=%b op=%h, expected 0 0", i, out_valid, op);
            end
        end
        fw_wb[4] = 128'hA5; fw_addr_wb[4] = 7'd5; fw_write_wb[4] = 1'b1; #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL perm_release: in_ready=%b, expected 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || ra !== 128'hA5 || pc_out !== 8'h31) begin
            n_err++; $display("FAIL perm_fwd: valid=%b ra=%h pc=%h, expected 1 a5 31", out_valid, ra, pc_out);
        end
        n_vec++;
        if (stall_cnt !== 16'd3) begin
            n_err++; $display("FAIL perm_stall_cnt: stall_cnt=%0d, expected 3", stall_cnt);
        end
        clear_bus(); idle(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_ls_raw();
        int stalls;
        do_reset();
        set_instr(2'd1, 7'd9, 7'd50, 7'd51, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
        tick();
        set_instr(2'd0, 7'd41, 7'd52, 7'd9, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
        stalls = 0;
        while (in_ready !== 1'b1 && stalls < 20) begin
            tick();
            stalls++;
        end
        n_vec++;
        if (stalls != 5) begin
            n_err++; $display("FAIL ls_stall_cycles: saw %0d, expected 5", stalls);
        end
        fw_wb[6] = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        fw_addr_wb[6] = 7'd9; fw_write_wb[6] = 1'b1; #1;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || rb !== 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978) begin
            n_err++; $display("FAIL ls_fwd: valid=%b rb=%h, expected 1 123456789abcdef00f1e2d3c4b5a6978", out_valid, rb);
        end
        n_vec++;
        if (stall_cnt !== 16'd5) begin
            n_err++; $display("FAIL ls_stall_cnt: stall_cnt=%0d, expected 5", stall_cnt);
        end
        clear_bus(); idle(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        do_reset();
        fw_wb[2] = 128'd1; fw_addr_wb[2] = 7'd7; fw_write_wb[2] = 1'b1;
        fw_wb[5] = 128'd2; fw_addr_wb[5] = 7'd7; fw_write_wb[5] = 1'b1;
        rt_wb = 128'd3; rt_addr_wb = 7'd7; reg_write_wb = 1'b1;
        fw_wb[0] = 128'd9; fw_addr_wb[0] = 7'd7; fw_write_wb[0] = 1'b1;
        set_instr(2'd0, 7'd60, 7'd7, 7'd61, 7'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'h50);
        tick();
        n_vec++;
        if (ra !== 128'd1 || rt_st !== 128'd1) begin
            n_err++; $display("FAIL prio_fw2: ra=%h rt_st=%h, expected 1 1", ra, rt_st);
        end
        fw_write_wb[2] = 1'b0; #1;
        tick();
        n_vec++;
        if (ra !== 128'd2) begin
            n_err++; $display("FAIL prio_fw5: ra=%h, expected 2", ra);
        end
        fw_write_wb[5] = 1'b0; #1;
        tick();
        n_vec++;
        if (ra !== 128'd3) begin
            n_err++; $display("FAIL prio_wb: ra=%h, expected 3", ra);
        end
        reg_write_wb = 1'b0; #1;
        tick();
        n_vec++;
        if (ra !== rf_value(7'd7) || rb !== rf_value(7'd61)) begin
            n_err++; $display("FAIL prio_rf_slot0_ignored: ra=%h rb=%h, expected %h %h", ra, rb, rf_value(7'd7), rf_value(7'd61));
        end
        clear_bus(); idle(2);
    endtask

    // ------------------------------------------------------------------
    task automatic test_branch_link();
        do_reset();
        set_instr(2'd2, 7'd8, 7'd70, 7'd71, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h58);
        tick();
        set_instr(2'd0, 7'd72, 7'd8, 7'd73, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59);
        fw_wb[1] = 128'hB00; fw_addr_wb[1] = 7'd8; fw_write_wb[1] = 1'b1; #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL br_no_stall: in_ready=%b, expected 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || ra !== 128'hB00) begin
            n_err++; $display("FAIL br_fwd1: valid=%b ra=%h, expected 1 b00", out_valid, ra);
        end
        clear_bus(); idle(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        do_reset();
        set_instr(2'd0, 7'd3, 7'd4, 7'd5, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h60);
        flush = 1'b1; #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0 || op !== 11'd0) begin
            n_err++; $display("FAIL flush_bubble: valid=%b reg_write=%b op=%h, expected 0 0 0", out_valid, reg_write, op);
        end
        flush = 1'b0; #1;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || reg_write !== 1'b1 || pc_out !== 8'h60 || rt_addr !== 7'd3) begin
            n_err++; $display("FAIL flush_replay: valid=%b reg_write=%b pc=%h rt=%0d, expected 1 1 60 3", out_valid, reg_write, pc_out, rt_addr);
        end
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL flush_stall_cnt: stall_cnt=%0d, expected 0", stall_cnt);
        end
        idle(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_stall();
        do_reset();
        set_instr(2'd1, 7'd9, 7'd80, 7'd81, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h70);
        tick();
        set_instr(2'd0, 7'd82, 7'd83, 7'd9, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h71);
        tick(); tick();
        n_vec++;
        if (stall_cnt !== 16'd2 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL midstall_pre: stall_cnt=%0d in_ready=%b, expected 2 0", stall_cnt, in_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        n_vec++;
        if (out_valid !== 1'b0 || op !== 11'd0 || rb !== 128'd0 || stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL midstall_outputs: valid=%b op=%h rb=%h stall=%0d, expected all 0", out_valid, op, rb, stall_cnt);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL midstall_ready: in_ready=%b, expected 1 (scoreboard empty)", in_ready);
        end
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_independent();
        test_perm_raw();
        test_ls_raw();
        test_priority();
        test_branch_link();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end

endmodule : tb_odd_operand_fwd
`default_nettype wire

// File: doc/odd_operand_fwd.md
Name: odd_operand_fwd

Overview:
- Register-fetch/forward stage that feeds the odd pipe. Sits between decode and the odd pipe, and consumes the odd pipe's forwarding staging bus (fw_wb/fw_addr_wb/fw_write_wb) and its writeback outputs.
- Resolves the ra, rb and rt_st operands from the youngest forwarded value, then writeback, then the register file.
- Tracks in-flight odd-pipe writes in a scoreboard. Stalls issue, inserting bubbles, until a needed result has reached a forwarding slot.

Parameters:
- DEPTH, 7: number of in-flight scoreboard ages tracked; matches forwarding slots 0..6.
- LAT_PERM, 4: age at which a permute result is valid in the forwarding bus.
- LAT_LS, 6: age at which a local-store result is valid.
- LAT_BR, 1: age at which a branch link result is valid.
- STALL_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  instruction accepted this cycle
- in_op  in  [0:10]  decoded opcode
- in_format  in  [2:0]  format
- in_unit  in  [1:0]  0 perm, 1 LS, 2 br, 3 treated as perm
- in_rt_addr  in  [0:6]  destination register
- in_ra_addr, in_rb_addr, in_rc_addr  in  [0:6]  source registers; rc supplies rt_st
- in_use_ra, in_use_rb, in_use_rc  in  1  each source is actually read
- in_imm  in  [0:17]  immediate
- in_reg_write  in  1  instruction writes the register table
- in_pc  in  [7:0]  program counter
- rf_ra_addr, rf_rb_addr, rf_rc_addr  out  [0:6]  register-file read addresses (combinational copies of the in_*_addr inputs)
- rf_ra, rf_rb, rf_rc  in  [0:127]  register-file read data (combinational)
- fw_wb  in  [6:0][0:127]  forwarding values
- fw_addr_wb  in  [6:0][0:6]  forwarding addresses
- fw_write_wb  in  [6:0]  forwarding valid bits
- rt_wb  in  [0:127]  writeback value
- rt_addr_wb  in  [0:6]  writeback address
- reg_write_wb  in  1  writeback valid
- flush  in  1  branch_taken from the odd pipe
- op  out  [0:10]  registered opcode to the odd pipe
- format  out  [2:0]  registered format
- unit  out  [1:0]  registered unit
- rt_addr  out  [0:6]  registered destination
- imm  out  [0:17]  registered immediate
- reg_write  out  1  registered write enable
- pc_out  out  [7:0]  registered program counter
- ra, rb, rt_st  out  [0:127]  registered resolved operands
- out_valid  out  1  registered outputs hold a real instruction
- stall_cnt  out  STALL_W  saturating count of hazard-stall cycles

Behaviour:
- Reset, synchronous:
  - All registered outputs are 0, out_valid is 0 and stall_cnt is 0.
  - All scoreboard entries are invalid.
  - in_ready is not gated by reset; it reflects the empty scoreboard and so reads 1.
- Scoreboard:
  - DEPTH entries of {valid, addr, lat}, shifted one age every cycle; age 1 is the newest.
  - An instruction is dispatched on the edge where in_valid && in_ready && !flush.
  - On dispatch, age 1 loads {in_reg_write, in_rt_addr, lat}. lat is LAT_PERM, LAT_LS or LAT_BR, selected by unit; unit 3 uses LAT_PERM.
  - Otherwise age 1 loads invalid.
  - An entry leaves after age DEPTH; by then the register file holds the value.
- Hazard (combinational):
  - A used source matches a valid entry of age a with a < lat.
  - in_ready = !hazard.
- Operand resolution (combinational, per source, registered at dispatch):
  - Pick fw slot k=1..6 with fw_write_wb[k] and a matching address, lowest k first.
  - Otherwise use rt_wb if reg_write_wb and rt_addr_wb match.
  - Otherwise use the rf_* data.
  - fw slot 0 is ignored.
- Latency: one cycle from accept to registered outputs with out_valid=1.
- No accept (hazard, !in_valid or flush): next cycle is a bubble, with out_valid=0 and reg_write=0. op, format and unit are 0, so downstream sees a no-op.
- Flush:
  - Overrides accept; the instruction in decode is not consumed, and in_ready is still reported as computed.
  - The output register becomes a bubble.
  - Existing scoreboard entries are kept and continue aging.
- stall_cnt increments on each cycle with in_valid && hazard && !flush, and saturates at all ones.
- Simultaneous events:
  - Reset beats flush, and flush beats accept.
  - Two in-flight entries to the same address: the hazard check considers each entry independently.

Decomposition:
- Shared package spu_pkg holds:
  - unit encodings (UNIT_PERM, UNIT_LS, UNIT_BR);
  - latency constants;
  - typedef sb_entry_t {valid, addr[0:6], lat[2:0]}.
- One sub-module, fwd_select: a purely combinational per-operand priority mux (fw slots, then wb, then rf). It is instantiated three times.

Test Plan:
- Independent stream: 3 perm instrs with no shared registers and in_valid held -> out_valid=1 on consecutive cycles; ra/rb equal rf data; stall_cnt=0.
- Perm RAW: perm writes r5, next instr reads ra=r5 -> in_ready=0 for 3 cycles with 3 bubbles, then accept. ra equals the fw_wb[4] value 128'hA5 driven by the bench; stall_cnt=3.
- LS RAW: LS writes r9, next instr reads rb=r9 -> 5 stall cycles; rb equals the fw_wb[6] value.
- Priority: fw[2], fw[5] and rt_wb all carry addr 7 with values 1, 2, 3; r7 not in the scoreboard -> ra=1.
- Flush: flush=1 while in_valid=1 with no hazard -> next cycle out_valid=0, reg_write=0; the same instruction is accepted the following cycle.
- Reset mid-stall: reset asserted during an LS hazard -> all outputs 0, scoreboard empty, in_ready=1 on the next cycle; stall_cnt=0.
